// File: rtl/memory_chip_master.sv
// memory_chip_master: valid/ready request front-end that sequences an active-low memory-chip port.
// Optional power-up zero sweep of the chip is enabled by defining MEMORY_CHIP_MASTER_CLEAR_EN.
module memory_chip_master #(
    parameter int nCells    = 8,
    parameter int WORD_SIZE = 8,
    parameter int RD_LAT    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [$clog2(nCells)-1:0] req_addr,
    input  logic [WORD_SIZE-1:0]      req_wdata,
    output logic                      rsp_valid,
    output logic [WORD_SIZE-1:0]      rsp_rdata,
    output logic                      busy,
    output logic                      mem_CS_bar,
    output logic                      mem_WE_bar,
    output logic [$clog2(nCells)-1:0] mem_Address,
    output logic [WORD_SIZE-1:0]      mem_DataIn,
    input  logic [WORD_SIZE-1:0]      mem_DataOut
);

    localparam int AW = $clog2(nCells);
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [AW:0]   CELLS    = (AW+1)'(nCells);
    localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);
    localparam logic [LW-1:0] LAT_ONE  = LW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
`ifdef MEMORY_CHIP_MASTER_CLEAR_EN
        , CLEAR = 2'd3
`endif
    } state_t;

`ifdef MEMORY_CHIP_MASTER_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
    localparam int CW = $clog2(nCells + 1);
    localparam logic [CW-1:0] CLR_END = CW'(nCells);
    localparam logic [CW-1:0] CLR_ONE = CW'(1);
    logic [CW-1:0] clr_cnt, clr_cnt_nxt;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t                state, state_nxt;
    logic [LW-1:0]         lat_cnt, lat_cnt_nxt;
    logic                  oor, oor_nxt;
    logic                  addr_oor;
    logic                  cs_nxt, we_nxt, rdy_nxt, busy_nxt, rv_nxt;
    logic [AW-1:0]         addr_nxt;
    logic [WORD_SIZE-1:0]  din_nxt, rd_nxt;

    // Addresses past the last cell only exist when nCells is not a power of two.
    assign addr_oor = ({1'b0, req_addr} >= CELLS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RESET_STATE;
            lat_cnt     <= '0;
            oor         <= 1'b0;
            mem_CS_bar  <= 1'b1;
            mem_WE_bar  <= 1'b1;
            mem_Address <= '0;
            mem_DataIn  <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            req_ready   <= 1'b0;
            busy        <= 1'b0;
`ifdef MEMORY_CHIP_MASTER_CLEAR_EN
            clr_cnt     <= '0;
`endif
        end else begin
            state       <= state_nxt;
            lat_cnt     <= lat_cnt_nxt;
            oor         <= oor_nxt;
            mem_CS_bar  <= cs_nxt;
            mem_WE_bar  <= we_nxt;
            mem_Address <= addr_nxt;
            mem_DataIn  <= din_nxt;
            rsp_valid   <= rv_nxt;
            rsp_rdata   <= rd_nxt;
            req_ready   <= rdy_nxt;
            busy        <= busy_nxt;
`ifdef MEMORY_CHIP_MASTER_CLEAR_EN
            clr_cnt     <= clr_cnt_nxt;
`endif
        end
    end

    // Outputs are computed for the state being entered, so every port comes straight from a flop.
    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        oor_nxt     = oor;
        cs_nxt      = mem_CS_bar;
        we_nxt      = mem_WE_bar;
        addr_nxt    = mem_Address;
        din_nxt     = mem_DataIn;
        rv_nxt      = 1'b0;
        rd_nxt      = rsp_rdata;
        rdy_nxt     = req_ready;
        busy_nxt    = busy;
`ifdef MEMORY_CHIP_MASTER_CLEAR_EN
        clr_cnt_nxt = clr_cnt;
`endif
        case (state)
            IDLE: begin
                rdy_nxt  = 1'b1;
                busy_nxt = 1'b0;
                cs_nxt   = 1'b1;
                we_nxt   = 1'b1;
                if (req_valid && req_ready) begin
                    addr_nxt = req_addr;
                    din_nxt  = req_wdata;
                    oor_nxt  = addr_oor;
                    rdy_nxt  = 1'b0;
                    busy_nxt = 1'b1;
                    if (req_we) begin
                        state_nxt = WRITE;
                        cs_nxt    = addr_oor;
                        we_nxt    = addr_oor;
                    end else begin
                        state_nxt   = READ;
                        lat_cnt_nxt = LAT_LAST;
                        cs_nxt      = addr_oor;
                        we_nxt      = 1'b1;
                    end
                end
            end
            WRITE: begin
                state_nxt = IDLE;
                cs_nxt    = 1'b1;
                we_nxt    = 1'b1;
                rdy_nxt   = 1'b1;
                busy_nxt  = 1'b0;
            end
            READ: begin
                if (lat_cnt == '0) begin
                    state_nxt = IDLE;
                    cs_nxt    = 1'b1;
                    we_nxt    = 1'b1;
                    rv_nxt    = 1'b1;
                    rd_nxt    = oor ? '0 : mem_DataOut;
                    rdy_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                end else begin
                    lat_cnt_nxt = lat_cnt - LAT_ONE;
                end
            end
`ifdef MEMORY_CHIP_MASTER_CLEAR_EN
            CLEAR: begin
                if (clr_cnt == CLR_END) begin
                    state_nxt = IDLE;
                    cs_nxt    = 1'b1;
                    we_nxt    = 1'b1;
                    rdy_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                end else begin
                    cs_nxt      = 1'b0;
                    we_nxt      = 1'b0;
                    addr_nxt    = clr_cnt[AW-1:0];
                    din_nxt     = '0;
                    rdy_nxt     = 1'b0;
                    busy_nxt    = 1'b1;
                    clr_cnt_nxt = clr_cnt + CLR_ONE;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
                cs_nxt    = 1'b1;
                we_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_chip_master.sv
// Bench for memory_chip_master: three instances (default, RD_LAT=3, nCells=6) each with a chip model.
module tb_memory_chip_master;

    localparam int ND  = 3;
    localparam int RL0 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              preload;
    logic [ND-1:0]     req_valid, req_we, req_ready, rsp_valid, busy, m_cs, m_we;
    logic [2:0]        req_addr  [ND];
    logic [2:0]        m_addr    [ND];
    logic [7:0]        req_wdata [ND];
    logic [7:0]        rsp_rdata [ND];
    logic [7:0]        m_din     [ND];
    logic [7:0]        m_dout    [ND];
    logic [7:0]        mem       [ND][8];

    int vectors     = 0;
    int miscompares = 0;
    int oor_hits    = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int NC = (g == 2) ? 6 : 8;
        localparam int RL = (g == 1) ? 3 : 1;
        memory_chip_master #(.nCells(NC), .WORD_SIZE(8), .RD_LAT(RL)) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .busy(busy[g]),
            .mem_CS_bar(m_cs[g]), .mem_WE_bar(m_we[g]), .mem_Address(m_addr[g]),
            .mem_DataIn(m_din[g]), .mem_DataOut(m_dout[g])
        );
        assign m_dout[g] = mem[g][m_addr[g]];
    end

    // Chip models: asynchronous read, write committed on the edge ending a CS/WE-low cycle.
    always @(posedge clk) begin
        if (preload) begin
            for (int g = 0; g < ND; g++)
                for (int i = 0; i < 8; i++)
                    mem[g][i] <= 8'hFF;
        end else begin
            for (int g = 0; g < ND; g++)
                if (!m_cs[g] && !m_we[g]) mem[g][m_addr[g]] <= m_din[g];
        end
    end

    always @(negedge clk)
        if (!m_cs[2] && m_addr[2] >= 3'd6) oor_hits <= oor_hits + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic xfer(input int g, input logic we, input logic [2:0] a, input logic [7:0] d);
        int n;
        req_valid[g] = 1'b1; req_we[g] = we; req_addr[g] = a; req_wdata[g] = d;
        n = 0;
        @(negedge clk);
        while (!req_ready[g] && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) begin
            vectors++; miscompares++;
            $display("FAIL xfer_timeout dut%0d: req_ready stayed 0, expected 1", g);
        end
        @(posedge clk); #1;
        req_valid[g] = 1'b0;
    endtask

    task automatic read_expect(input int g, input logic [2:0] a, input logic [7:0] exp,
                               input int lat, input string nm);
        int k;
        xfer(g, 1'b0, a, 8'h00);
        k = 0;
        do begin @(negedge clk); k++; end while (!rsp_valid[g] && k < 20);
        check({nm, "_latency"}, k, lat + 1);
        check({nm, "_data"}, rsp_rdata[g], exp);
        @(negedge clk);
        check({nm, "_pulse"}, rsp_valid[g], 1'b0);
        @(posedge clk); #1;
    endtask

    // Reference model for the randomized phase on instance 0: cycle-numbered access windows.
    int         cyc, acc_s, acc_e, rsp_cyc;
    logic       acc_we;
    logic [2:0] acc_a;
    logic [7:0] acc_d, rsp_d;
    logic [7:0] model [8];

    task automatic monitor_step();
        logic in_acc;
        logic exp_rdy;
        cyc++;
        in_acc  = (cyc >= acc_s) && (cyc <= acc_e);
        exp_rdy = !in_acc;
        check("rnd_ready", req_ready[0], exp_rdy);
        check("rnd_busy", busy[0], !exp_rdy);
        check("rnd_cs_bar", m_cs[0], !in_acc);
        check("rnd_we_bar", m_we[0], !(in_acc && acc_we));
        if (in_acc) check("rnd_addr", m_addr[0], acc_a);
        if (in_acc && acc_we) check("rnd_din", m_din[0], acc_d);
        check("rnd_rsp_valid", rsp_valid[0], cyc == rsp_cyc);
        if (cyc == rsp_cyc) check("rnd_rdata", rsp_rdata[0], rsp_d);
        if (req_valid[0] && exp_rdy) begin
            acc_s  = cyc + 1;
            acc_e  = cyc + (req_we[0] ? 1 : RL0);
            acc_we = req_we[0];
            acc_a  = req_addr[0];
            acc_d  = req_wdata[0];
            if (req_we[0]) model[req_addr[0]] = req_wdata[0];
            else begin
                rsp_cyc = cyc + RL0 + 1;
                rsp_d   = model[req_addr[0]];
            end
        end
    endtask

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int   n;
        logic pend, hs;

        tbl[0] = '{1'b1, 3'd0, 8'h11, 8'h00};
        tbl[1] = '{1'b1, 3'd1, 8'h22, 8'h00};
        tbl[2] = '{1'b1, 3'd2, 8'h33, 8'h00};
        tbl[3] = '{1'b1, 3'd3, 8'h44, 8'h00};
        tbl[4] = '{1'b0, 3'd0, 8'h00, 8'h11};
        tbl[5] = '{1'b0, 3'd1, 8'h00, 8'h22};
        tbl[6] = '{1'b0, 3'd2, 8'h00, 8'h33};
        tbl[7] = '{1'b0, 3'd3, 8'h00, 8'h44};

        rst = 1'b1; preload = 1'b1;
        req_valid = '0; req_we = '0;
        for (int g = 0; g < ND; g++) begin req_addr[g] = '0; req_wdata[g] = '0; end

        // Reset values, held during reset and for the cycle after release
        repeat (2) @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        check("rst_cs_bar", m_cs[0], 1'b1);
        check("rst_we_bar", m_we[0], 1'b1);
        check("rst_addr", m_addr[0], 3'd0);
        check("rst_din", m_din[0], 8'h00);
        check("rst_rsp_valid", rsp_valid, 3'b000);
        check("rst_rdata", rsp_rdata[0], 8'h00);
        check("rst_ready", req_ready, 3'b000);
        check("rst_busy", busy, 3'b000);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", req_ready, 3'b000);
        check("post_rst_cs_bar", m_cs, 3'b111);
        check("post_rst_busy", busy, 3'b000);
`ifdef MEMORY_CHIP_MASTER_CLEAR_EN
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("clr_cs_bar", m_cs[0], 1'b0);
            check("clr_we_bar", m_we[0], 1'b0);
            check("clr_addr", m_addr[0], 3'(k));
            check("clr_busy", busy[0], 1'b1);
            check("clr_ready", req_ready[0], 1'b0);
        end
        @(negedge clk);
        check("clr_done_ready", req_ready[0], 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) read_expect(0, 3'(i), 8'h00, 1, "clr_read");
`else
        @(negedge clk);
        check("idle_ready", req_ready, 3'b111);
        check("idle_busy", busy, 3'b000);
        @(posedge clk); #1;
`endif

        // Single write then read back
        xfer(0, 1'b1, 3'd3, 8'hA5);
        @(negedge clk);
        check("t1_wr_cs_bar", m_cs[0], 1'b0);
        check("t1_wr_we_bar", m_we[0], 1'b0);
        check("t1_wr_addr", m_addr[0], 3'd3);
        check("t1_wr_din", m_din[0], 8'hA5);
        check("t1_wr_ready", req_ready[0], 1'b0);
        check("t1_wr_busy", busy[0], 1'b1);
        @(negedge clk);
        check("t1_after_cs_bar", m_cs[0], 1'b1);
        check("t1_after_ready", req_ready[0], 1'b1);
        @(posedge clk); #1;
        read_expect(0, 3'd3, 8'hA5, 1, "t1_rd");

        // Back-to-back table with req_valid held high throughout
        req_valid[0] = 1'b1;
        req_we[0] = tbl[0].we; req_addr[0] = tbl[0].addr; req_wdata[0] = tbl[0].wdata;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (!req_ready[0] && n < 20) begin @(negedge clk); n++; end
            check("b2b_no_stall", n, 0);
            if (i > 0 && !tbl[i-1].we) begin
                check("b2b_rsp_valid", rsp_valid[0], 1'b1);
                check("b2b_rdata", rsp_rdata[0], tbl[i-1].exp);
            end
            @(posedge clk); #1;
            if (i < 7) begin
                req_we[0] = tbl[i+1].we; req_addr[0] = tbl[i+1].addr; req_wdata[0] = tbl[i+1].wdata;
            end else req_valid[0] = 1'b0;
            @(negedge clk);
            check("b2b_ready_low", req_ready[0], 1'b0);
            @(negedge clk);
        end
        check("b2b_last_rsp_valid", rsp_valid[0], 1'b1);
        check("b2b_last_rdata", rsp_rdata[0], tbl[7].exp);
        @(posedge clk); #1;

        // RD_LAT=3 read
        xfer(1, 1'b1, 3'd7, 8'h3C);
        xfer(1, 1'b0, 3'd7, 8'h00);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("lat3_cs_bar", m_cs[1], 1'b0);
            check("lat3_we_bar", m_we[1], 1'b1);
            check("lat3_addr", m_addr[1], 3'd7);
            check("lat3_no_rsp", rsp_valid[1], 1'b0);
        end
        @(negedge clk);
        check("lat3_end_cs_bar", m_cs[1], 1'b1);
        check("lat3_rsp_valid", rsp_valid[1], 1'b1);
        check("lat3_rdata", rsp_rdata[1], 8'h3C);
        @(posedge clk); #1;

        // Reset in the middle of a read
        xfer(1, 1'b0, 3'd7, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_cs_before", m_cs[1], 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid_cs_bar", m_cs[1], 1'b1);
        check("rstmid_we_bar", m_we[1], 1'b1);
        check("rstmid_rsp_valid", rsp_valid[1], 1'b0);
        check("rstmid_ready", req_ready[1], 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rstmid_no_rsp", rsp_valid[1], 1'b0);
`ifndef MEMORY_CHIP_MASTER_CLEAR_EN
            if (k == 0) check("rstmid_ready_after", req_ready[1], 1'b1);
`endif
        end
        @(posedge clk); #1;

        // nCells=6: in-range access, then out-of-range write and read
        xfer(2, 1'b1, 3'd1, 8'h77);
        @(posedge clk); #1;
        read_expect(2, 3'd1, 8'h77, 1, "n6_in");
        xfer(2, 1'b1, 3'd6, 8'h55);
        @(negedge clk);
        check("n6_oor_wr_cs_bar", m_cs[2], 1'b1);
        check("n6_oor_wr_busy", busy[2], 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        read_expect(2, 3'd6, 8'h00, 1, "n6_oor_rd");
        check("n6_oor_access", oor_hits, 0);
        check("n6_oor_nowrite", mem[2][6], 8'hFF);

        // Randomized traffic on instance 0 against the reference model
        for (int i = 0; i < 8; i++) begin
            model[i] = 8'($urandom);
            xfer(0, 1'b1, 3'(i), model[i]);
        end
        @(posedge clk); #1;
        cyc = 0; acc_s = -100; acc_e = -100; rsp_cyc = -100;
        acc_we = 1'b0; acc_a = '0; acc_d = '0; rsp_d = '0;
        pend = 1'b0;
        for (int t = 0; t < 420; t++) begin
            if (t >= 400) req_valid[0] = 1'b0;
            else if (!pend) begin
                if ($urandom_range(0, 3) != 0) begin
                    req_valid[0] = 1'b1;
                    req_we[0]    = 1'($urandom_range(0, 1));
                    req_addr[0]  = 3'($urandom_range(0, 7));
                    req_wdata[0] = 8'($urandom);
                    pend = 1'b1;
                end else req_valid[0] = 1'b0;
            end
            @(negedge clk);
            hs = req_valid[0] && req_ready[0];
            monitor_step();
            @(posedge clk); #1;
            if (hs) pend = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1);
    end

endmodule
